// File: rtl/uart_cmd_decoder.sv
// Decodes 'W' addr data / 'R' addr byte commands from the UART into single-cycle
// register-bus accesses and returns exactly one response byte per completed command.
`timescale 1ns/1ps

module uart_cmd_decoder #(
    parameter int          BYTE_TIMEOUT = 206250,
    parameter int          RD_TIMEOUT   = 16,
    parameter logic [7:0]  CMD_WR       = 8'h57,
    parameter logic [7:0]  CMD_RD       = 8'h52,
    parameter logic [7:0]  RSP_OK       = 8'h4B,
    parameter logic [7:0]  RSP_ERR      = 8'h3F,
    parameter logic [7:0]  RSP_TO       = 8'h45
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_rdy,
    input  logic        tx_ack,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [7:0]  reg_rdata,
    input  logic        reg_rvalid,
    output logic        busy,
    output logic        err_timeout
);

    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int RT_W = $clog2(RD_TIMEOUT + 1);

    // Timers expire on the cycle whose increment would reach the limit.
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXEC_WR,
        EXEC_RD,
        WAIT_RD,
        SEND
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        opcode_reg, opcode_next;
    logic [7:0]        reg_addr_reg, reg_addr_next;
    logic [7:0]        reg_wdata_reg, reg_wdata_next;
    logic [7:0]        tx_data_reg, tx_data_next;
    logic [BT_W-1:0]   byte_timer_reg, byte_timer_next;
    logic [RT_W-1:0]   rd_timer_reg, rd_timer_next;
    logic              err_timeout_reg, err_timeout_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            opcode_reg      <= 8'h00;
            reg_addr_reg    <= 8'h00;
            reg_wdata_reg   <= 8'h00;
            tx_data_reg     <= 8'h00;
            byte_timer_reg  <= '0;
            rd_timer_reg    <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            opcode_reg      <= opcode_next;
            reg_addr_reg    <= reg_addr_next;
            reg_wdata_reg   <= reg_wdata_next;
            tx_data_reg     <= tx_data_next;
            byte_timer_reg  <= byte_timer_next;
            rd_timer_reg    <= rd_timer_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        opcode_next      = opcode_reg;
        reg_addr_next    = reg_addr_reg;
        reg_wdata_next   = reg_wdata_reg;
        tx_data_next     = tx_data_reg;
        byte_timer_next  = byte_timer_reg;
        rd_timer_next    = rd_timer_reg;
        err_timeout_next = 1'b0;

        case (state_reg)
            IDLE: begin
                byte_timer_next = '0;
                if (rx_rdy) begin
                    opcode_next = rx_data;
                    if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                        state_next = GET_ADDR;
                    end else begin
                        tx_data_next = RSP_ERR;
                        state_next   = SEND;
                    end
                end
            end

            GET_ADDR: begin
                if (rx_rdy) begin
                    reg_addr_next   = rx_data;
                    byte_timer_next = '0;
                    state_next      = (opcode_reg == CMD_WR) ? GET_DATA : EXEC_RD;
                end else if (byte_timer_reg == BT_LAST) begin
                    err_timeout_next = 1'b1;
                    byte_timer_next  = '0;
                    state_next       = IDLE;
                end else begin
                    byte_timer_next = byte_timer_reg + 1'b1;
                end
            end

            GET_DATA: begin
                if (rx_rdy) begin
                    reg_wdata_next  = rx_data;
                    byte_timer_next = '0;
                    state_next      = EXEC_WR;
                end else if (byte_timer_reg == BT_LAST) begin
                    err_timeout_next = 1'b1;
                    byte_timer_next  = '0;
                    state_next       = IDLE;
                end else begin
                    byte_timer_next = byte_timer_reg + 1'b1;
                end
            end

            EXEC_WR: begin
                tx_data_next = RSP_OK;
                state_next   = SEND;
            end

            EXEC_RD: begin
                rd_timer_next = '0;
                state_next    = WAIT_RD;
            end

            // Data arriving on the expiry cycle still takes precedence over the timeout.
            WAIT_RD: begin
                if (reg_rvalid) begin
                    tx_data_next = reg_rdata;
                    state_next   = SEND;
                end else if (rd_timer_reg == RT_LAST) begin
                    tx_data_next = RSP_TO;
                    state_next   = SEND;
                end else begin
                    rd_timer_next = rd_timer_reg + 1'b1;
                end
            end

            SEND: begin
                if (tx_ack) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes decode straight from state so reset clears them without waiting for a clock.
    assign rx_ack      = rx_rdy && (state_reg == IDLE || state_reg == GET_ADDR ||
                                    state_reg == GET_DATA);
    assign reg_wr      = (state_reg == EXEC_WR);
    assign reg_rd      = (state_reg == EXEC_RD);
    assign tx_rdy      = (state_reg == SEND);
    assign busy        = (state_reg != IDLE);
    assign tx_data     = tx_data_reg;
    assign reg_addr    = reg_addr_reg;
    assign reg_wdata   = reg_wdata_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: directed commands push expected bus/response
// events into queues; a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps

module tb_uart_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_rdy;
    logic       tx_ack = 1'b0;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_rvalid = 1'b0;
    logic       busy;
    logic       err_timeout;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .BYTE_TIMEOUT (100),
        .RD_TIMEOUT   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .rx_ack      (rx_ack),
        .tx_data     (tx_data),
        .tx_rdy      (tx_rdy),
        .tx_ack      (tx_ack),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int          exp_to = 0;
    int          ack_cnt = 0;
    int          rd_delay = 0;
    logic [7:0]  rd_value = 8'h00;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: one line per observed transaction, compared against the scoreboard.
    logic [15:0] mon_wr;
    logic [7:0]  mon_b;
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_ack) begin
                ack_cnt++;
                $display("[%0t] rx byte %02h accepted", $time, rx_data);
            end
            if (reg_wr) begin
                $display("[%0t] reg_wr addr %02h data %02h", $time, reg_addr, reg_wdata);
                if (exp_wr.size() == 0) check("unexpected reg_wr", reg_wr, 0);
                else begin
                    mon_wr = exp_wr.pop_front();
                    check("reg_wr addr/data", {reg_addr, reg_wdata}, mon_wr);
                end
            end
            if (reg_rd) begin
                $display("[%0t] reg_rd addr %02h", $time, reg_addr);
                if (exp_rd.size() == 0) check("unexpected reg_rd", reg_rd, 0);
                else begin
                    mon_b = exp_rd.pop_front();
                    check("reg_rd addr", reg_addr, mon_b);
                end
            end
            if (tx_rdy && tx_ack) begin
                $display("[%0t] tx byte %02h sent", $time, tx_data);
                if (exp_tx.size() == 0) check("unexpected tx byte", tx_rdy, 0);
                else begin
                    mon_b = exp_tx.pop_front();
                    check("tx_data", tx_data, mon_b);
                end
            end
            if (err_timeout) begin
                $display("[%0t] err_timeout pulse", $time);
                if (exp_to == 0) check("unexpected err_timeout", err_timeout, 0);
                else exp_to--;
            end
        end
    end

    // Register-file model: answers a read strobe after rd_delay cycles (negative = never).
    always @(negedge clk) begin
        if (!rst && reg_rd && rd_delay >= 0) begin
            repeat (rd_delay) @(posedge clk);
            #1;
            reg_rdata  = rd_value;
            reg_rvalid = 1'b1;
            @(posedge clk);
            #1;
            reg_rvalid = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        rx_data = b;
        rx_rdy  = 1'b1;
        forever begin
            @(negedge clk);
            n++;
            if (rx_ack || n >= 500) break;
        end
        if (!rx_ack) check("rx_ack wait", 0, 1);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
    endtask

    task automatic wait_tx(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (tx_rdy || n >= 300) break;
        end
        if (!tx_rdy) check("tx_rdy wait", 0, 1);
    endtask

    task automatic ack_tx();
        @(posedge clk);
        #1;
        tx_ack = 1'b1;
        @(posedge clk);
        #1;
        tx_ack = 1'b0;
        @(negedge clk);
        check("idle after tx_ack", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad_stable;
        int bad_ack;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_rdy", tx_rdy, 0);
        check("reset busy", busy, 0);
        check("reset reg_wr/reg_rd", {reg_wr, reg_rd}, 0);
        check("reset err_timeout", err_timeout, 0);
        check("reset tx_data", tx_data, 8'h00);
        check("reset reg_addr/wdata", {reg_addr, reg_wdata}, 16'h0000);
        rst = 1'b0;

        // Write: W 10 A5 -> reg_wr, response K two cycles after last byte
        ack_cnt = 0;
        exp_wr.push_back(16'h10A5);
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'hA5);
        wait_tx(n);
        check("write response latency", n, 2);
        ack_tx();
        check("write rx_ack pulses", ack_cnt, 3);
        check("reg_addr held", reg_addr, 8'h10);

        // Read with data 3 cycles after reg_rd
        rd_delay = 3;
        rd_value = 8'h3C;
        exp_rd.push_back(8'h22);
        exp_tx.push_back(8'h3C);
        send_byte(8'h52);
        send_byte(8'h22);
        wait_tx(n);
        check("read response latency", n, 5);
        ack_tx();

        // Read never answered -> 'E' after 16 cycles in WAIT_RD
        rd_delay = -1;
        exp_rd.push_back(8'h22);
        exp_tx.push_back(8'h45);
        send_byte(8'h52);
        send_byte(8'h22);
        wait_tx(n);
        check("read timeout latency", n, 18);
        ack_tx();

        // Bad opcode -> '?'
        exp_tx.push_back(8'h3F);
        send_byte(8'h00);
        wait_tx(n);
        check("bad opcode latency", n, 1);
        ack_tx();

        // Inter-byte timeout in GET_DATA
        exp_to = 1;
        send_byte(8'h57);
        send_byte(8'h10);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (err_timeout || n >= 400) break;
        end
        check("byte timeout latency", n, 101);
        check("no tx_rdy on timeout", tx_rdy, 0);
        check("idle on timeout", busy, 0);
        @(negedge clk);
        check("err_timeout pulse width", err_timeout, 0);
        check("timeout event consumed", exp_to, 0);

        // Following read works
        rd_delay = 1;
        rd_value = 8'h5A;
        exp_rd.push_back(8'h10);
        exp_tx.push_back(8'h5A);
        send_byte(8'h52);
        send_byte(8'h10);
        wait_tx(n);
        check("read after timeout latency", n, 3);
        ack_tx();

        // SEND held 50 cycles with rx_rdy high
        exp_wr.push_back(16'h3377);
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(8'h33);
        send_byte(8'h77);
        wait_tx(n);
        @(posedge clk);
        #1;
        rx_data = 8'h99;
        rx_rdy  = 1'b1;
        bad_stable = 0;
        bad_ack = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!tx_rdy || tx_data !== 8'h4B) bad_stable++;
            if (rx_ack) bad_ack++;
        end
        check("tx held stable cycles bad", bad_stable, 0);
        check("rx_ack while in SEND", bad_ack, 0);
        rx_rdy = 1'b0;
        ack_tx();

        // Asynchronous reset in GET_DATA
        send_byte(8'h57);
        send_byte(8'h44);
        @(negedge clk);
        check("busy in GET_DATA", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset busy", busy, 0);
        check("async reset reg_addr", reg_addr, 8'h00);
        check("async reset tx_data", tx_data, 8'h00);
        check("async reset strobes", {tx_rdy, reg_wr, reg_rd, err_timeout}, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("no activity after reset", {busy, tx_rdy}, 2'b00);

        check("exp_tx drained", exp_tx.size(), 0);
        check("exp_wr drained", exp_wr.size(), 0);
        check("exp_rd drained", exp_rd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
